// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Arbitrates SDRAM bus ownership between the init, auto-refresh, write and
// read stages, then muxes the owning stage's command/bank/address onto the
// SDRAM pins and drives DQ during writes.
//
// Arbitration: after init_end the arbiter idles in ARBIT. Refresh wins
// outright. A contested write/read request is granted round-robin against
// the last data-stage grant. A granted stage keeps the bus until its own
// *_end; there is no pre-emption.
//
// Ports
//   sys_clk, sys_rst_n               clock (rising edge), async active-low reset
//   init_end, init_cmd/ba/addr       init stage done flag and its command
//   aref_req/end, aref_cmd/ba/addr   refresh request, done flag and command
//   wr_req/end, write_cmd/ba/addr    write request, burst done and command
//   wr_sdram_en, wr_sdram_data       DQ drive enable and data from write stage
//   rd_req/end, read_cmd/ba/addr     read request, burst done and command
//   aref_en, wr_en, rd_en            grant to refresh / write / read stage
//   sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
//   sdram_ba, sdram_addr             SDRAM command pins
//   sdram_dq                         SDRAM data bus (driven only for writes)
//
// Build option
//   SDRAM_ARBIT_CMD_REG_EN  when defined, command pins and the DQ data and
//   enable are registered (one cycle of latency, all aligned). Grants are
//   never affected by this option.
// -----------------------------------------------------------------------------
module sdram_arbit (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  write_cmd,
    input  logic [1:0]  write_ba,
    input  logic [12:0] write_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  read_cmd,
    input  logic [1:0]  read_ba,
    input  logic [12:0] read_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    inout  wire  [15:0] sdram_dq
);

    localparam logic [2:0] INIT  = 3'd0;
    localparam logic [2:0] ARBIT = 3'd1;
    localparam logic [2:0] AREF  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [1:0]  BA_IDLE  = 2'b11;
    localparam logic [12:0] ADR_IDLE = 13'h1fff;

    localparam logic GRANT_WRITE = 1'b0;
    localparam logic GRANT_READ  = 1'b1;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        last_grant;

    logic [3:0]  cmd_mux;
    logic [1:0]  ba_mux;
    logic [12:0] addr_mux;
    logic        dq_en_mux;

    logic [3:0]  cmd_out;
    logic [1:0]  ba_out;
    logic [12:0] addr_out;
    logic        dq_en_out;
    logic [15:0] dq_data_out;

    // Each *_end is only looked at in its own state, so a stray end from a
    // stage that does not own the bus is ignored.
    always_comb begin
        next_state = state;
        case (state)
            INIT:  if (init_end) next_state = ARBIT;
            ARBIT: begin
                if (aref_req)
                    next_state = AREF;
                else if (wr_req && rd_req)
                    next_state = (last_grant == GRANT_READ) ? WRITE : READ;
                else if (wr_req)
                    next_state = WRITE;
                else if (rd_req)
                    next_state = READ;
            end
            AREF:    if (aref_end) next_state = ARBIT;
            WRITE:   if (wr_end)   next_state = ARBIT;
            READ:    if (rd_end)   next_state = ARBIT;
            default: next_state = INIT;
        endcase
    end

    // last_grant starts at READ so the first contested grant goes to write;
    // refresh grants leave it alone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= INIT;
            last_grant <= GRANT_READ;
        end else begin
            state <= next_state;
            if (state == ARBIT && next_state == WRITE)
                last_grant <= GRANT_WRITE;
            else if (state == ARBIT && next_state == READ)
                last_grant <= GRANT_READ;
        end
    end

    assign aref_en = (state == AREF);
    assign wr_en   = (state == WRITE);
    assign rd_en   = (state == READ);

    always_comb begin
        cmd_mux  = CMD_NOP;
        ba_mux   = BA_IDLE;
        addr_mux = ADR_IDLE;
        case (state)
            INIT:  begin cmd_mux = init_cmd;  ba_mux = init_ba;  addr_mux = init_addr;  end
            AREF:  begin cmd_mux = aref_cmd;  ba_mux = aref_ba;  addr_mux = aref_addr;  end
            WRITE: begin cmd_mux = write_cmd; ba_mux = write_ba; addr_mux = write_addr; end
            READ:  begin cmd_mux = read_cmd;  ba_mux = read_ba;  addr_mux = read_addr;  end
            default: ;
        endcase
    end

    assign dq_en_mux = (state == WRITE) && wr_sdram_en;

`ifdef SDRAM_ARBIT_CMD_REG_EN
    // ---- output register stage: pins lag the mux by one cycle ----
    logic [3:0]  cmd_p1;
    logic [1:0]  ba_p1;
    logic [12:0] addr_p1;
    logic        dq_en_p1;
    logic [15:0] dq_data_p1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_p1   <= CMD_NOP;
            ba_p1    <= BA_IDLE;
            addr_p1  <= ADR_IDLE;
            dq_en_p1 <= 1'b0;
        end else begin
            cmd_p1   <= cmd_mux;
            ba_p1    <= ba_mux;
            addr_p1  <= addr_mux;
            dq_en_p1 <= dq_en_mux;
        end
    end

    // Data needs no reset: the bus stays released until dq_en_p1 is set.
    always_ff @(posedge sys_clk) begin
        dq_data_p1 <= wr_sdram_data;
    end

    assign cmd_out     = cmd_p1;
    assign ba_out      = ba_p1;
    assign addr_out    = addr_p1;
    assign dq_en_out   = dq_en_p1;
    assign dq_data_out = dq_data_p1;
`else
    assign cmd_out     = cmd_mux;
    assign ba_out      = ba_mux;
    assign addr_out    = addr_mux;
    assign dq_en_out   = dq_en_mux;
    assign dq_data_out = wr_sdram_data;
`endif

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_out;
    assign sdram_ba   = ba_out;
    assign sdram_addr = addr_out;
    assign sdram_dq   = dq_en_out ? dq_data_out : 16'hzzzz;

endmodule
